counter_run_ctrl: RTL

COUNTER_RUN_CTRL -- requirements
Module: counter_run_ctrl

---
 rtl/counter_pkg.sv | 15 +
 rtl/mod_counter.sv | 38 +++
 rtl/counter_run_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared widths and FSM state encoding for the run controller
package counter_pkg;

  localparam int CNT_W_DEF = 17;
  localparam int PER_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-(limit+1) up counter with clear and terminal-count flag
module mod_counter #(
  parameter int CNT_W = counter_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] data,
  output logic             wrap
);

  logic [CNT_W-1:0] data_q;
  logic [CNT_W-1:0] data_d;

  // Comparing against limit before incrementing means limit = all-ones never overflows.
  assign wrap = en && (data_q == limit);
  assign data = data_q;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = wrap ? '0 : data_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - run controller: counts cfg_periods full periods of 0..cfg_limit
module counter_run_ctrl
  import counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic [PER_W-1:0] cfg_periods,
  output logic [CNT_W-1:0] data,
  output logic             wrap,
  output logic [PER_W-1:0] period_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [PER_W-1:0] periods_q, periods_d;
  logic [PER_W-1:0] period_cnt_q, period_cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_wrap;

  assign cnt_en     = (state_q == ST_RUN);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign wrap       = cnt_wrap;
  assign period_cnt = period_cnt_q;
  assign done       = done_q;
  assign err        = err_q;

  mod_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (limit_q),
    .data  (data),
    .wrap  (cnt_wrap)
  );

  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    periods_d    = periods_q;
    period_cnt_d = period_cnt_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cnt_clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        limit_d      = cfg_limit;
        periods_d    = cfg_periods;
        period_cnt_d = '0;
        cnt_clr      = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if ((cfg_limit == '0) || (cfg_periods == '0)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort takes priority even over the wrap that would finish the run.
        if (abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_wrap) begin
          period_cnt_d = period_cnt_q + PER_W'(1);
          if (period_cnt_d == periods_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      limit_q      <= '0;
      periods_q    <= '0;
      period_cnt_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      limit_q      <= limit_d;
      periods_q    <= periods_d;
      period_cnt_q <= period_cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule
